smoldvi_tmds_serialiser: RTL and testbench
==========================================

Name: smoldvi_tmds_serialiser

Overview:
- Converts one 10-bit TMDS symbol per pixel period into 2-bit DDR pairs, one pair per clk_x5 cycle, for a single DVI data lane.
- Sits in the clk_x5 (half-rate bit clock) domain, beside the pixel-clock lane driver.
- Upstream is the per-lane TMDS encoder path (already crossed into clk_x5). Downstream are two ODDRX1F primitives, p and n.
- Replaces the generic 10:1 serialiser for data lanes: no internal CDC, one symbol of buffering, deterministic 5-cycle symbol framing.

Parameters:
- IDLE_SYMBOL, 10'b1101010100, symbol sent on underrun and after reset (TMDS control token c1c0=00).
- INVERT, 0, 1 = swap lane polarity (dp/dn outputs exchanged via bit inversion).
- UNDERRUN_CNT_W, 8, width of the saturating underrun counter.

Ports:
- clk_x5  in  1  half-rate bit clock (5x pixel clock).
- rst_x5  in  1  asynchronous, active-high reset.
- in_data  in  10  TMDS symbol, bit 0 transmitted first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- dp  out  2  DDR pair for the p ODDR. dp[0] goes to D0 (first half-bit), dp[1] to D1.
- dn  out  2  DDR pair for the n ODDR. Always the bitwise complement of dp.
- sym_start  out  1  high in the cycle dp carries bits [1:0] of a symbol.
- underrun  out  1  sticky: a symbol boundary occurred with the buffer empty.
- underrun_clr  in  1  clears underrun and the underrun counter.
- underrun_cnt  out  UNDERRUN_CNT_W  saturating count of underrun events.

Behaviour:
- Reset (async, while rst_x5=1) sets the following:
  - phase = 0
  - sr = IDLE_SYMBOL
  - buf_valid = 0
  - dp = 2'b00, dn = 2'b11 (polarity applied)
  - sym_start = 0
  - underrun = 0, underrun_cnt = 0
- phase:
  - 3-bit counter 0,1,2,3,4,0…
  - Free-running from reset release. Never stalls.
  - Values 5–7 are unreachable. If reached, the next value is 0.
- Shift register sr[9:0], updated every cycle:
  - When phase==4: sr <= buf_valid ? buf : IDLE_SYMBOL.
  - Otherwise: sr <= sr >> 2 (zero-fill).
- Output registers, updated every cycle:
  - dp <= sr[1:0] ^ {2{INVERT}}.
  - dn <= ~(sr[1:0] ^ {2{INVERT}}).
  - sym_start <= (phase==0).
  - Consequence: a symbol loaded at phase 4 appears on dp as bits [1:0],[3:2],…,[9:8] over the following five cycles, starting 2 cycles after the load edge.
- Buffer: a single register buf with flag buf_valid.
  - in_ready = !buf_valid || (phase==4). This is combinational from registers only; there is no path from in_valid.
  - A transfer occurs when in_valid && in_ready. Then buf <= in_data and buf_valid <= 1.
  - If phase==4 with no transfer, buf_valid <= 0.
  - If phase==4 with a transfer, the old buf moves to sr, the new data is taken, and buf_valid stays 1.
  - There is no bypass: data accepted in a phase-4 cycle is serialised at the next boundary, not the current one.
  - Upstream must hold in_data stable while in_valid && !in_ready.
- Underrun event: phase==4 && !buf_valid.
  - Sets underrun.
  - Increments underrun_cnt, saturating at all-ones.
  - underrun_clr clears both. If underrun_clr and an event occur in the same cycle, the event wins: underrun=1, cnt=1.
  - The first boundary after reset counts as an underrun unless a symbol was accepted in cycles 0–3 after reset release.
- Steady state: the upstream provides exactly one symbol per 5 cycles, with no underrun and no backpressure loss.
- Reset mid-symbol: outputs return to reset values immediately. The partial symbol is discarded. Framing restarts at phase 0 on release.

Decomposition:
- Shared smoldvi package holds:
  - TMDS control-token constants (the four c1c0 tokens), IDLE_SYMBOL default from the package.
  - SYMBOL_W=10 and PHASE_MAX=4.
- One natural sub-module: smoldvi_ddr_out, wrapping the ODDRX1F pair plus the __ICARUS__ behavioural mux, shared with the lane clock driver.

Test Plan:
- Reset release, in_valid=0 for 20 cycles: dp follows IDLE_SYMBOL pairs {00,01,01,01,11} (as dp[1:0] per cycle), repeating every 5 cycles. underrun=1, underrun_cnt=4.
- One symbol per 5 cycles, values 10'h3FF, 10'h000, 10'h2AA: dp sequences are 11×5, 00×5, then 10×5. sym_start is high on the first pair of each symbol. underrun_cnt stays 0 once streaming.
- in_valid held high continuously: in_ready is low except in phase-4 cycles after the first accept. No symbol is lost or duplicated across 50 symbols (scoreboard).
- Stall upstream for one boundary mid-stream: exactly one IDLE_SYMBOL is inserted, underrun_cnt increments by 1, and the stream resumes with the next symbol intact.
- underrun_clr asserted in the same cycle as an underrun event: underrun=1, cnt=1. 300 consecutive underruns: cnt saturates at 255.
- Assert rst_x5 at phase 2 mid-symbol: dp=00, dn=11, and buf_valid=0 immediately. After release, phase restarts at 0. Run again with INVERT=1: dp equals ~dp of the INVERT=0 run.

Source files
------------

// File: rtl/smoldvi_pkg.sv
// Shared smoldvi constants: TMDS control tokens, symbol width and
// symbol framing used by the lane serialisers and clock driver.
package smoldvi_pkg;

   localparam int SYMBOL_W  = 10;
   localparam int PHASE_MAX = 4;

   // TMDS control tokens indexed by {c1,c0}.
   localparam logic [SYMBOL_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
   localparam logic [SYMBOL_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
   localparam logic [SYMBOL_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
   localparam logic [SYMBOL_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

   localparam logic [SYMBOL_W-1:0] IDLE_SYMBOL_DEFAULT = TMDS_CTRL_00;

   localparam logic [2:0] PH_FIRST = 3'd0;
   localparam logic [2:0] PH_LAST  = 3'(PHASE_MAX);

endpackage

// File: rtl/smoldvi_ddr_out.sv
// Registered DDR pair feeding the p/n output ODDRs of one lane.
// Polarity swap is done by inversion so both pads stay symmetric.
module smoldvi_ddr_out #(
   parameter bit INVERT = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] d_i,
   output logic [1:0] p_o,
   output logic [1:0] n_o
);

   logic [1:0] p_q;
   logic [1:0] p_d;

   always_comb begin
      p_d = d_i ^ {2{INVERT}};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) p_q <= {2{INVERT}};
      else       p_q <= p_d;
   end

   assign p_o = p_q;
   assign n_o = ~p_q;

endmodule

// File: rtl/smoldvi_tmds_serialiser.sv
// Data-lane TMDS serialiser: one 10-bit symbol per 5 clk_x5 cycles,
// emitted as 2-bit DDR pairs, with a single symbol of buffering.
module smoldvi_tmds_serialiser
   import smoldvi_pkg::*;
#(
   parameter logic [SYMBOL_W-1:0] IDLE_SYMBOL    = IDLE_SYMBOL_DEFAULT,
   parameter bit                  INVERT         = 1'b0,
   parameter int                  UNDERRUN_CNT_W = 8
) (
   input  logic                      clk_x5,
   input  logic                      rst_x5,
   input  logic [SYMBOL_W-1:0]       in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [1:0]                dp,
   output logic [1:0]                dn,
   output logic                      sym_start,
   output logic                      underrun,
   input  logic                      underrun_clr,
   output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

   localparam logic [UNDERRUN_CNT_W-1:0] CNT_ONE = 1;

   logic [2:0]                phase_q, phase_d;
   logic [SYMBOL_W-1:0]       sr_q, sr_d;
   logic [SYMBOL_W-1:0]       buf_q, buf_d;
   logic                      buf_valid_q, buf_valid_d;
   logic                      sym_start_q, sym_start_d;
   logic                      underrun_q, underrun_d;
   logic [UNDERRUN_CNT_W-1:0] cnt_q, cnt_d;

   logic boundary;
   logic xfer;
   logic urun_evt;

   always_comb begin
      boundary = (phase_q == PH_LAST);
      in_ready = !buf_valid_q || boundary;
      xfer     = in_valid && in_ready;
      urun_evt = boundary && !buf_valid_q;

      // Out-of-range phases fold back to 0 so framing self-recovers.
      phase_d = (phase_q >= PH_LAST) ? PH_FIRST : phase_q + 3'd1;

      sr_d = sr_q >> 2;
      if (boundary) sr_d = buf_valid_q ? buf_q : IDLE_SYMBOL;

      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      if (xfer) begin
         buf_d       = in_data;
         buf_valid_d = 1'b1;
      end else if (boundary) begin
         buf_valid_d = 1'b0;
      end

      sym_start_d = (phase_q == PH_FIRST);

      // An underrun in the same cycle as a clear still gets recorded.
      underrun_d = underrun_q;
      cnt_d      = cnt_q;
      if (urun_evt) begin
         underrun_d = 1'b1;
         if (underrun_clr) cnt_d = CNT_ONE;
         else if (!(&cnt_q)) cnt_d = cnt_q + CNT_ONE;
      end else if (underrun_clr) begin
         underrun_d = 1'b0;
         cnt_d      = '0;
      end
   end

   always_ff @(posedge clk_x5 or posedge rst_x5) begin
      if (rst_x5) begin
         phase_q     <= PH_FIRST;
         sr_q        <= IDLE_SYMBOL;
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         sym_start_q <= 1'b0;
         underrun_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         phase_q     <= phase_d;
         sr_q        <= sr_d;
         buf_q       <= buf_d;
         buf_valid_q <= buf_valid_d;
         sym_start_q <= sym_start_d;
         underrun_q  <= underrun_d;
         cnt_q       <= cnt_d;
      end
   end

   smoldvi_ddr_out #(
      .INVERT (INVERT)
   ) u_ddr_out (
      .clk_i (clk_x5),
      .rst_i (rst_x5),
      .d_i   (sr_q[1:0]),
      .p_o   (dp),
      .n_o   (dn)
   );

   assign sym_start    = sym_start_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_smoldvi_tmds_serialiser.sv
// Directed bench for smoldvi_tmds_serialiser, normal and inverted lanes
// driven side by side from the same stimulus.
module tb_smoldvi_tmds_serialiser;

   localparam logic [9:0] IDLE = 10'b1101010100;

   logic       clk_x5 = 1'b0;
   logic       rst_x5 = 1'b1;
   logic [9:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       underrun_clr = 1'b0;

   logic       in_ready, sym_start, underrun;
   logic [1:0] dp, dn;
   logic [7:0] underrun_cnt;

   logic       in_ready_i, sym_start_i, underrun_i;
   logic [1:0] dp_i, dn_i;
   logic [7:0] cnt_i;

   int errors = 0;
   int checks = 0;
   int k = 0;
   bit chk_en = 1'b0;
   bit auto_sb = 1'b0;
   logic [9:0] exp_sym [0:319];

   always #5 clk_x5 = ~clk_x5;

   smoldvi_tmds_serialiser #(
      .IDLE_SYMBOL    (IDLE),
      .INVERT         (1'b0),
      .UNDERRUN_CNT_W (8)
   ) dut (
      .clk_x5       (clk_x5),
      .rst_x5       (rst_x5),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .dp           (dp),
      .dn           (dn),
      .sym_start    (sym_start),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .underrun_cnt (underrun_cnt)
   );

   smoldvi_tmds_serialiser #(
      .IDLE_SYMBOL    (IDLE),
      .INVERT         (1'b1),
      .UNDERRUN_CNT_W (8)
   ) dut_inv (
      .clk_x5       (clk_x5),
      .rst_x5       (rst_x5),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready_i),
      .dp           (dp_i),
      .dn           (dn_i),
      .sym_start    (sym_start_i),
      .underrun     (underrun_i),
      .underrun_clr (underrun_clr),
      .underrun_cnt (cnt_i)
   );

   function automatic logic [1:0] pair_of(input logic [9:0] s, input int p);
      logic [9:0] t;
      t = s >> (2 * p);
      return t[1:0];
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h cycle=%0d",
                tag, obs, expv, k);
      end
   endtask

   task automatic tick();
      logic       acc;
      logic [9:0] d;
      logic [1:0] e, e_n;
      int         j, p;
      acc = in_valid && in_ready;
      d   = in_data;
      @(posedge clk_x5);
      #1;
      k++;
      if (auto_sb && acc) exp_sym[k/5+1] = d;
      if (chk_en) begin
         j   = (k - 1) / 5;
         p   = (k - 1) % 5;
         e   = pair_of(exp_sym[j], p);
         e_n = ~e;
         chk("dp", {14'd0, dp}, {14'd0, e});
         chk("dn", {14'd0, dn}, {14'd0, e_n});
         chk("dp_inv", {14'd0, dp_i}, {14'd0, e_n});
         chk("dn_inv", {14'd0, dn_i}, {14'd0, e});
         chk("sym_start", {15'd0, sym_start}, {15'd0, p == 0});
         chk("sym_start_inv", {15'd0, sym_start_i}, {15'd0, p == 0});
      end
   endtask

   task automatic do_reset();
      rst_x5       = 1'b1;
      in_valid     = 1'b0;
      underrun_clr = 1'b0;
      chk_en       = 1'b0;
      auto_sb      = 1'b0;
      repeat (2) @(posedge clk_x5);
      #1;
      chk("rst_dp", {14'd0, dp}, 16'h0);
      chk("rst_dn", {14'd0, dn}, 16'h3);
      chk("rst_dp_inv", {14'd0, dp_i}, 16'h3);
      chk("rst_dn_inv", {14'd0, dn_i}, 16'h0);
      chk("rst_sym_start", {15'd0, sym_start}, 16'h0);
      chk("rst_underrun", {15'd0, underrun}, 16'h0);
      chk("rst_cnt", {8'd0, underrun_cnt}, 16'h0);
      chk("rst_ready", {15'd0, in_ready}, 16'h1);
      for (int i = 0; i < 320; i++) exp_sym[i] = IDLE;
      k      = 0;
      rst_x5 = 1'b0;
      chk_en = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit a;

      // Idle after reset: IDLE pairs repeat, four boundary underruns.
      do_reset();
      repeat (20) tick();
      chk("idle_underrun", {15'd0, underrun}, 16'h1);
      chk("idle_cnt", {8'd0, underrun_cnt}, 16'd4);
      chk("idle_cnt_inv", {8'd0, cnt_i}, 16'd4);
      chk("idle_underrun_inv", {15'd0, underrun_i}, 16'h1);

      // One symbol per frame: 3FF, 000, 2AA.
      do_reset();
      exp_sym[1] = 10'h3FF;
      exp_sym[2] = 10'h000;
      exp_sym[3] = 10'h2AA;
      in_valid = 1'b1;
      in_data  = 10'h3FF;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("stream_ready_ph4", {15'd0, in_ready}, 16'h1);
      in_valid = 1'b1;
      in_data  = 10'h000;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      in_valid = 1'b1;
      in_data  = 10'h2AA;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      chk("stream_cnt", {8'd0, underrun_cnt}, 16'd0);
      chk("stream_underrun", {15'd0, underrun}, 16'h0);
      tick();
      chk("stream_end_cnt", {8'd0, underrun_cnt}, 16'd1);

      // Continuous in_valid: 50 symbols through the scoreboard.
      do_reset();
      auto_sb  = 1'b1;
      n        = 0;
      in_valid = 1'b1;
      in_data  = 10'($urandom);
      while (n < 50 && k < 300) begin
         chk("cont_ready", {15'd0, in_ready},
             {15'd0, (k == 0) || (k % 5 == 4)});
         a = in_valid && in_ready;
         tick();
         if (a) begin
            n++;
            in_data = 10'($urandom);
         end
      end
      in_valid = 1'b0;
      chk("cont_accepted", 16'(n), 16'd50);
      while (k < 254) tick();
      chk("cont_cnt", {8'd0, underrun_cnt}, 16'd0);
      tick();
      chk("cont_tail_cnt", {8'd0, underrun_cnt}, 16'd1);
      auto_sb = 1'b0;

      // Upstream skips one boundary: exactly one IDLE inserted.
      do_reset();
      exp_sym[1] = 10'h155;
      exp_sym[2] = 10'h0AA;
      exp_sym[3] = 10'h3C3;
      exp_sym[4] = IDLE;
      exp_sym[5] = 10'h17E;
      exp_sym[6] = 10'h281;
      while (k < 35) begin
         in_valid = 1'b1;
         case (k)
            0:       in_data = 10'h155;
            4:       in_data = 10'h0AA;
            9:       in_data = 10'h3C3;
            19:      in_data = 10'h17E;
            24:      in_data = 10'h281;
            default: in_valid = 1'b0;
         endcase
         if (k == 19) chk("stall_cnt_before", {8'd0, underrun_cnt}, 16'd0);
         tick();
         if (k == 20) begin
            chk("stall_cnt_after", {8'd0, underrun_cnt}, 16'd1);
            chk("stall_underrun", {15'd0, underrun}, 16'h1);
         end
         if (k == 34) chk("stall_cnt_resume", {8'd0, underrun_cnt}, 16'd1);
      end
      in_valid = 1'b0;

      // Clear racing an underrun, then counter saturation.
      do_reset();
      repeat (4) tick();
      underrun_clr = 1'b1;
      tick();
      chk("clr_race_underrun", {15'd0, underrun}, 16'h1);
      chk("clr_race_cnt", {8'd0, underrun_cnt}, 16'd1);
      tick();
      chk("clr_underrun", {15'd0, underrun}, 16'h0);
      chk("clr_cnt", {8'd0, underrun_cnt}, 16'd0);
      underrun_clr = 1'b0;
      while (k < 1279) tick();
      chk("sat_cnt_254", {8'd0, underrun_cnt}, 16'd254);
      tick();
      chk("sat_cnt_255", {8'd0, underrun_cnt}, 16'd255);
      while (k < 1505) tick();
      chk("sat_cnt_hold", {8'd0, underrun_cnt}, 16'd255);
      chk("sat_cnt_hold_inv", {8'd0, cnt_i}, 16'd255);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      chk("sat_clr_cnt", {8'd0, underrun_cnt}, 16'd0);

      // Reset mid-symbol at phase 2 with a symbol waiting in the buffer.
      do_reset();
      exp_sym[1] = 10'h3FF;
      in_valid = 1'b1;
      in_data  = 10'h3FF;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      in_valid = 1'b1;
      in_data  = 10'h000;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk_en = 1'b0;
      #2;
      rst_x5 = 1'b1;
      #1;
      chk("mid_rst_dp", {14'd0, dp}, 16'h0);
      chk("mid_rst_dn", {14'd0, dn}, 16'h3);
      chk("mid_rst_dp_inv", {14'd0, dp_i}, 16'h3);
      chk("mid_rst_dn_inv", {14'd0, dn_i}, 16'h0);
      chk("mid_rst_sym_start", {15'd0, sym_start}, 16'h0);
      chk("mid_rst_ready", {15'd0, in_ready}, 16'h1);
      chk("mid_rst_ready_inv", {15'd0, in_ready_i}, 16'h1);
      do_reset();
      repeat (10) tick();
      chk("post_rst_cnt", {8'd0, underrun_cnt}, 16'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
